jedro_1_dram_arbiter: RTL and testbench
=======================================

// Module: jedro_1_dram_arbiter
// PURPOSE
//  Shares the single data RAM port (bytewrite RAM wrapper) between two requesters:
//  m0 = jedro_1 core load/store unit, m1 = secondary master (DMA/debug loader).
//  Round-robin grant, one outstanding transaction, registered request path,
//  combinational response routing, and a bus timeout that converts a hung slave into err.
// PARAMETERS
//  DATA_WIDTH      32  data bus width (bits)
//  ADDR_WIDTH      32  byte address width
//  TIMEOUT_CYCLES  16  max cycles in BUSY without ack/err; 0 = timeout disabled
//  DRAM_SIZE_BYTES 4096 mapped RAM size; used only with JEDRO_1_DRAM_ARB_RANGE_CHECK_EN
// PORTS
//  clk_i          in  1   clock, all state on rising edge
//  rstn_i         in  1   reset, synchronous, active-low
//  m0_/m1_stb_i   in  1   request valid; held high with fields stable until ack/err
//  m0_/m1_we_i    in  4   byte write enables; 0000 = read
//  m0_/m1_addr_i  in  AW  byte address
//  m0_/m1_wdata_i in  DW  write data
//  m0_/m1_rdata_o out DW  read data, valid when ack_o=1
//  m0_/m1_ack_o   out 1   one-cycle completion pulse
//  m0_/m1_err_o   out 1   one-cycle error pulse (slave err, timeout, or range fault)
//  dram_stb_o     out 1   request to RAM (registered)
//  dram_we_o      out 4   byte enables to RAM (registered)
//  dram_addr_o    out AW  address to RAM (registered)
//  dram_wdata_o   out DW  write data to RAM (registered)
//  dram_rdata_i   in  DW  RAM read data
//  dram_ack_i     in  1   RAM completion
//  dram_err_i     in  1   RAM error
// BEHAVIOUR
//  - Reset (rstn_i=0 at clk edge): state=IDLE, last_grant=1 (m0 wins first), timeout cnt=0,
//    dram_stb_o/we_o/addr_o/wdata_o=0; m*_ack_o/err_o=0 and m*_rdata_o=0 (no grant).
//    Reset mid-transaction abandons it; no ack/err reaches either master.
//  - FSM IDLE: if exactly one stb_i, grant it; if both, grant the one != last_grant.
//    On grant: latch we/addr/wdata into dram_* regs, dram_stb_o<=1, last_grant<=winner,
//    -> BUSY. No request: stay IDLE.
//  - BUSY: dram_* regs frozen. Responses routed combinationally to the granted master only:
//    mX_rdata_o=dram_rdata_i, mX_ack_o=dram_ack_i&~dram_err_i, mX_err_o=dram_err_i.
//    Non-granted master sees ack=err=0, rdata=0. On dram_ack_i|dram_err_i:
//    dram_stb_o<=0, cnt<=0, -> IDLE. err wins if ack and err arrive together.
//  - Timeout: cnt increments each BUSY cycle without response; when cnt==TIMEOUT_CYCLES-1
//    and no response, granted mX_err_o=1 that cycle, dram_stb_o<=0, -> IDLE.
//    Late ack/err from RAM while IDLE is ignored (not forwarded).
//  - Latency: stb_i seen in IDLE at edge N -> dram_stb_o high after N; 1-cycle-ack RAM
//    completes at edge N+1 (mX_ack_o high in cycle N+1..N+2). Min 2 cycles/transaction;
//    one IDLE cycle between back-to-back grants.
//  - Fairness: with both masters requesting continuously, grants alternate m0,m1,m0,...
//  - A master dropping stb_i while granted does not abort the RAM access; it completes.
// CONFIGURATION
//  JEDRO_1_DRAM_ARB_RANGE_CHECK_EN defined: in IDLE, winner with addr_i>=DRAM_SIZE_BYTES
//    is not forwarded (dram_stb_o stays 0); mX_err_o=1 for one cycle in state FAULT,
//    then IDLE; last_grant still updates.
//  Undefined: no address check; all addresses forwarded to RAM; FAULT state absent.
// TESTING
//  1) m0 sw addr 0x0 wdata 13 we 1111 alone -> RAM[0]=13, m0_ack_o 1 pulse, m1 outputs 0.
//  2) m0,m1 stb same cycle (m0 addr 0x0=13, m1 addr 0x4=13) -> m0 served first, then m1;
//     RAM[0]=RAM[1]=13; 4 back-to-back requests each alternate m0,m1,m0,m1.
//  3) m1 read 0x4 after (2) -> m1_rdata_o=13 with m1_ack_o; m0_ack_o stays 0.
//  4) RAM ack held low, TIMEOUT_CYCLES=16 -> granted m*_err_o pulses on 16th BUSY cycle,
//     dram_stb_o falls next edge; later spurious dram_ack_i not forwarded.
//  5) rstn_i=0 in BUSY -> next edge all outputs 0, IDLE; first grant after reset to m0.
//  6) RANGE_CHECK_EN, m0 addr 0x1000 (size 4096) -> m0_err_o pulse, dram_stb_o never 1.

Source files
------------

// File: rtl/jedro_1_dram_arbiter.sv
// Round-robin arbiter sharing one data RAM port between the LSU (m0) and a secondary master (m1).
// Optional address range check: define JEDRO_1_DRAM_ARB_RANGE_CHECK_EN.
module jedro_1_dram_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int DRAM_SIZE_BYTES = 4096
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  m0_stb_i,
  input  logic [3:0]            m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_stb_i,
  input  logic [3:0]            m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  dram_stb_o,
  output logic [3:0]            dram_we_o,
  output logic [ADDR_WIDTH-1:0] dram_addr_o,
  output logic [DATA_WIDTH-1:0] dram_wdata_o,
  input  logic [DATA_WIDTH-1:0] dram_rdata_i,
  input  logic                  dram_ack_i,
  input  logic                  dram_err_i
);

`ifdef JEDRO_1_DRAM_ARB_RANGE_CHECK_EN
  typedef enum logic [1:0] {IDLE, BUSY, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t          state;
  logic            last_grant;
  logic            gnt;
  logic [CW-1:0]   cnt;

  logic                  busy;
  logic                  rsp;
  logic                  tmo;
  logic                  any_req;
  logic                  win;
  logic                  oor;
  logic                  err_x;
  logic                  ack_x;
  logic [3:0]            sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign busy    = (state == BUSY);
  assign rsp     = dram_ack_i | dram_err_i;
  assign tmo     = busy & ~rsp & (TIMEOUT_CYCLES != 0) & (cnt == CMAX);
  assign any_req = m0_stb_i | m1_stb_i;
  // m1 wins when alone, or when both ask and m0 was served last
  assign win     = m1_stb_i & (~m0_stb_i | ~last_grant);

  assign sel_we    = win ? m1_we_i    : m0_we_i;
  assign sel_addr  = win ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = win ? m1_wdata_i : m0_wdata_i;

`ifdef JEDRO_1_DRAM_ARB_RANGE_CHECK_EN
  assign oor   = (sel_addr >= ADDR_WIDTH'(DRAM_SIZE_BYTES));
  assign err_x = (busy & (dram_err_i | tmo)) | (state == FAULT);
`else
  assign oor   = 1'b0;
  assign err_x = busy & (dram_err_i | tmo);
`endif
  assign ack_x = busy & dram_ack_i & ~dram_err_i;

  assign m0_ack_o   = ack_x & ~gnt;
  assign m1_ack_o   = ack_x &  gnt;
  assign m0_err_o   = err_x & ~gnt;
  assign m1_err_o   = err_x &  gnt;
  assign m0_rdata_o = (busy & ~gnt) ? dram_rdata_i : '0;
  assign m1_rdata_o = (busy &  gnt) ? dram_rdata_i : '0;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      gnt          <= 1'b0;
      cnt          <= '0;
      dram_stb_o   <= 1'b0;
      dram_we_o    <= '0;
      dram_addr_o  <= '0;
      dram_wdata_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= win;
            gnt        <= win;
            cnt        <= '0;
            if (oor) begin
`ifdef JEDRO_1_DRAM_ARB_RANGE_CHECK_EN
              state <= FAULT;
`endif
            end else begin
              dram_stb_o   <= 1'b1;
              dram_we_o    <= sel_we;
              dram_addr_o  <= sel_addr;
              dram_wdata_o <= sel_wdata;
              state        <= BUSY;
            end
          end
        end
        BUSY: begin
          if (rsp || tmo) begin
            dram_stb_o <= 1'b0;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_dram_arbiter.sv
// Scoreboard bench for jedro_1_dram_arbiter: random two-master traffic plus
// directed arbitration, timeout, reset and range-fault cases.
module tb_jedro_1_dram_arbiter;

  localparam int TO = 16;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 0;
  logic        rstn = 0;
  logic        m0_stb = 0, m1_stb = 0;
  logic [3:0]  m0_we = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        dram_stb;
  logic [3:0]  dram_we;
  logic [31:0] dram_addr, dram_wdata;
  logic [31:0] ram_rdata = 0;
  logic        ram_ack = 0, ram_err = 0, spur = 0, hang = 0;

  int total = 0;
  int fails = 0;
  int rcnt[2] = '{0, 0};
  exp_t q0[$];
  exp_t q1[$];
  int   got_ord[$];
  logic [31:0] ref_mem[1024];
  logic [31:0] mem[1024];
  int   wait_c = 0;

  always #5 clk = ~clk;

  jedro_1_dram_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .dram_stb_o(dram_stb), .dram_we_o(dram_we),
    .dram_addr_o(dram_addr), .dram_wdata_o(dram_wdata),
    .dram_rdata_i(ram_rdata), .dram_ack_i(ram_ack | spur),
    .dram_err_i(ram_err)
  );

  // RAM slave: random extra latency, 0x200 address bit returns err
  always @(posedge clk) begin
    ram_ack <= 1'b0;
    ram_err <= 1'b0;
    if (dram_stb && !ram_ack && !ram_err && !hang) begin
      if (wait_c > 0) begin
        wait_c <= wait_c - 1;
      end else begin
        wait_c <= $urandom_range(0, 2);
        if (dram_addr[9]) begin
          ram_err <= 1'b1;
        end else begin
          ram_ack   <= 1'b1;
          ram_rdata <= mem[dram_addr[11:2]];
          for (int b = 0; b < 4; b++)
            if (dram_we[b])
              mem[dram_addr[11:2]][8*b +: 8] <= dram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic resp(input int m, input logic ack, input logic err,
                      input logic [31:0] rd, input logic oae,
                      input logic [31:0] ord);
    exp_t e;
    bit   ok;
    if (!(ack || err)) return;
    total++;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      fails++;
      $display("FAIL unexpected_m%0d: got ack=%0b err=%0b want none",
               m, ack, err);
    end else begin
      e  = (m == 0) ? q0.pop_front() : q1.pop_front();
      ok = (err == e.err) && (ack == !e.err) && !oae && (ord == 0);
      if (e.rd && !e.err && rd !== e.data) ok = 0;
      if (!ok) begin
        fails++;
        $display("FAIL resp_m%0d: got ack=%0b err=%0b rdata=%0h other=%0b/%0h want err=%0b rdata=%0h",
                 m, ack, err, rd, oae, ord, e.err, e.data);
      end
    end
    got_ord.push_back(m);
    rcnt[m]++;
  endtask

  always @(negedge clk) begin
    resp(0, m0_ack, m0_err, m0_rdata, m1_ack | m1_err, m1_rdata);
    resp(1, m1_ack, m1_err, m1_rdata, m0_ack | m0_err, m0_rdata);
  end

  task automatic drive(input int m, input logic s, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] wd);
    if (m == 0) begin
      m0_stb = s; m0_we = we; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_stb = s; m1_we = we; m1_addr = a; m1_wdata = wd;
    end
  endtask

  task automatic issue(input int m, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   c0;
    bit   seen;
    e.err = a[9];
`ifdef JEDRO_1_DRAM_ARB_RANGE_CHECK_EN
    if (a >= 32'd4096) e.err = 1;
`endif
    e.rd   = (we == 0);
    e.data = ref_mem[a[11:2]];
    if (!e.err)
      for (int b = 0; b < 4; b++)
        if (we[b]) ref_mem[a[11:2]][8*b +: 8] = wd[8*b +: 8];
    if (m == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    c0 = rcnt[m];
    drive(m, 1, we, a, wd);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (rcnt[m] != c0);
    end
    if (!seen) begin
      total++; fails++;
      $display("FAIL no_response_m%0d: got none want ack/err", m);
      if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    drive(m, 0, 0, 0, 0);
  endtask

  task automatic rnd_master(input int m, input int n);
    logic [31:0] a;
    logic [3:0]  we;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = (m == 0) ? 32'h0 : 32'h100;
      a = a + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) a = a | 32'h200;
      we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      issue(m, we, a, $urandom);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dram_stb"}, 64'(dram_stb), 0);
    chk({tag, "_dram_we"}, 64'(dram_we), 0);
    chk({tag, "_dram_addr"}, 64'(dram_addr), 0);
    chk({tag, "_dram_wdata"}, 64'(dram_wdata), 0);
    chk({tag, "_m_ack_err"}, 64'({m0_ack, m0_err, m1_ack, m1_err}), 0);
    chk({tag, "_m_rdata"}, 64'({m0_rdata, m1_rdata}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_ord[6];
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 0;
      mem[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 chk_idle("reset");
    @(negedge clk) rstn = 1;

    // single write from m0
    issue(0, 4'hf, 32'h0, 32'd13);
    chk("ram0_after_m0_sw", 64'(mem[0]), 13);

    // hung slave -> timeout error on the 16th busy cycle
    hang = 1;
    q0.push_back('{err: 1, rd: 1, data: 0});
    @(negedge clk);
    n = rcnt[0];
    drive(0, 1, 0, 32'h10, 0);
    begin
      int busy_n;
      busy_n = 0;
      for (int i = 0; i < 40 && rcnt[0] == n; i++) begin
        @(negedge clk); #1;
        if (dram_stb) busy_n++;
      end
      chk("timeout_cycle", 64'(busy_n), TO);
    end
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("timeout_stb_fall", 64'(dram_stb), 0);
    @(negedge clk) spur = 1;
    @(negedge clk); #1;
    chk("late_ack_dropped", 64'({m0_ack, m1_ack}), 0);
    spur = 0;

    // reset while busy abandons the transfer
    @(negedge clk);
    drive(0, 1, 0, 32'h20, 0);
    repeat (3) @(negedge clk);
    rstn = 0;
    @(posedge clk); #1;
    chk_idle("midreset");
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    hang = 0;
    rstn = 1;

    // simultaneous requests, then back-to-back alternation
    got_ord.delete();
    fork
      issue(0, 4'hf, 32'h0, 32'd13);
      issue(1, 4'hf, 32'h4, 32'd13);
    join
    fork
      begin issue(0, 4'hf, 32'h8, 32'd7); issue(0, 0, 32'h0, 0); end
      begin issue(1, 4'hf, 32'hc, 32'd9); issue(1, 0, 32'h8, 0); end
    join
    exp_ord = '{0, 1, 0, 1, 0, 1};
    chk("order_len", 64'(got_ord.size()), 6);
    for (int i = 0; i < 6 && i < got_ord.size(); i++)
      chk($sformatf("order_%0d", i), 64'(got_ord[i]), 64'(exp_ord[i]));
    chk("ram1_value", 64'(mem[1]), 13);

    // m1 reads back the word it wrote
    issue(1, 0, 32'h4, 0);

`ifdef JEDRO_1_DRAM_ARB_RANGE_CHECK_EN
    begin
      bit stb_seen;
      stb_seen = 0;
      fork
        issue(0, 4'hf, 32'h1000, 32'd1);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (dram_stb) stb_seen = 1;
        end
      join
      chk("range_no_stb", 64'(stb_seen), 0);
    end
`endif

    fork
      rnd_master(0, 40);
      rnd_master(1, 40);
    join
    repeat (4) @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 0);
    chk("q1_drained", 64'(q1.size()), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
